puf_resp_vote: RTL and testbench
================================

PUF_RESP_VOTE -- requirements
Module: puf_resp_vote

Interface
REQ-001 The block SHALL have parameter RESP_W, default 32, meaning response width in bits (legal range: 2 or more).
REQ-002 The block SHALL have parameter VOTE_N, default 7, meaning evaluations per response bit (odd, 1 or more).
REQ-003 The block SHALL have parameter SETTLE_CYC, default 4, meaning wait cycles between launch and sample (1 or more).
REQ-004 The block SHALL have port clk, input, 1 bit, the clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit, a request to begin a response acquisition.
REQ-007 The block SHALL have port launch, output, 1 bit, a one-cycle race-launch pulse to the upstream arbiter-cell A/B drivers.
REQ-008 The block SHALL have port chal_sel, output, $clog2(RESP_W) bits, the index of the challenge/bit currently evaluated.
REQ-009 The block SHALL have port arb_bit, input, 1 bit, the arbiter-cell decision output C (synchronous to clk).
REQ-010 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-011 The block SHALL have port resp_valid, output, 1 bit, response available.
REQ-012 The block SHALL have port resp_ready, input, 1 bit, consumer accepts the response.
REQ-013 The block SHALL have port resp_data, output, RESP_W bits, the majority-voted response.
REQ-014 The block SHALL have port unstable_cnt, output, $clog2(RESP_W+1) bits, the number of bits with non-unanimous votes.

Function
REQ-015 The FSM SHALL have states IDLE, LAUNCH, SETTLE, SAMPLE and DONE, all outputs registered/Moore.
REQ-016 In IDLE, start=1 SHALL clear resp_data, unstable_cnt, chal_sel, the vote counter and the ones counter, and SHALL move to LAUNCH.
REQ-017 launch SHALL be 1 exactly while in LAUNCH (1 cycle), followed by the SETTLE state.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles, followed by the SAMPLE state.
REQ-019 In SAMPLE, arb_bit SHALL be captured on the edge leaving SAMPLE, incrementing ones_cnt (width $clog2(VOTE_N+1)) when it is 1, and incrementing vote_cnt.
REQ-020 When vote_cnt has not yet reached VOTE_N, the next state after SAMPLE SHALL be LAUNCH with the same chal_sel.
REQ-021 On the final vote, resp_data[chal_sel] SHALL be set to (ones_cnt_incl_current > VOTE_N/2, integer division), and unstable_cnt SHALL be incremented when 0 < ones < VOTE_N.
REQ-022 After each committed bit, ones_cnt and vote_cnt SHALL be cleared; if chal_sel==RESP_W-1 the next state SHALL be DONE, else chal_sel increments and the next state is LAUNCH.
REQ-023 Bit order SHALL be LSB first: bit k SHALL use challenge k.
REQ-024 Latency: resp_valid SHALL rise exactly RESP_W*VOTE_N*(SETTLE_CYC+2) edges after the edge that samples start.
REQ-025 In DONE, resp_valid=1 and resp_data/unstable_cnt SHALL be stable until the edge with resp_ready=1; then the next state SHALL be IDLE, resp_valid SHALL be 0, and data SHALL be held.
REQ-026 start SHALL be ignored in every state except IDLE, including the DONE cycle in which resp_ready=1 (no restart without a new start in IDLE).
REQ-027 resp_ready SHALL be ignored outside DONE.
REQ-028 In IDLE and DONE, chal_sel SHALL hold its last value and launch SHALL be 0.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and set launch, busy, resp_valid, chal_sel, resp_data, unstable_cnt and all internal counters to 0.
REQ-030 Reset mid-acquisition SHALL discard partial results; the next start SHALL restart from chal_sel=0.

Verification (RESP_W=4, VOTE_N=3, SETTLE_CYC=2)
REQ-031 Scenario: arb_bit held 1, start pulse -> 12 launch pulses, resp_valid at edge 48, resp_data=4'hF, unstable_cnt=0.
REQ-032 Scenario: arb_bit = ~chal_sel[0] -> resp_data=4'b0101, unstable_cnt=0.
REQ-033 Scenario: bit 1 votes 1,1,0 and bit 2 votes 0,1,0, others 0 -> resp_data=4'b0010, unstable_cnt=2.
REQ-034 Scenario: resp_ready low 10 cycles in DONE with start pulsed -> resp_valid/resp_data stable, no launch; resp_ready high -> IDLE next edge, busy=0.
REQ-035 Scenario: rst_n low during chal_sel=2 SETTLE -> all outputs 0 asynchronously; new start -> first launch with chal_sel=0, full 48-edge latency.
REQ-036 Scenario: start pulsed during SETTLE and SAMPLE -> ignored; launch count stays 12 and resp_valid stays at edge 48.

Source files
------------

// File: rtl/puf_resp_vote.sv
// Arbiter-PUF response acquisition: each response bit is evaluated VOTE_N times,
// majority-voted, and bits whose votes disagree are counted as unstable.
module puf_resp_vote #(
  parameter int RESP_W     = 32,
  parameter int VOTE_N     = 7,
  parameter int SETTLE_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       launch,
  output logic [$clog2(RESP_W)-1:0]  chal_sel,
  input  logic                       arb_bit,
  output logic                       busy,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [RESP_W-1:0]          resp_data,
  output logic [$clog2(RESP_W+1)-1:0] unstable_cnt
);

  localparam int CW = $clog2(RESP_W);
  localparam int VW = $clog2(VOTE_N + 1);
  localparam int UW = $clog2(RESP_W + 1);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [CW-1:0] CHAL_LAST   = CW'(RESP_W - 1);
  localparam logic [VW-1:0] VOTE_ALL    = VW'(VOTE_N);
  localparam logic [VW-1:0] VOTE_MAJ    = VW'(VOTE_N / 2);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  state_e            state_q;
  logic              launch_q;
  logic              busy_q;
  logic              resp_valid_q;
  logic [CW-1:0]     chal_sel_q;
  logic [RESP_W-1:0] resp_data_q;
  logic [UW-1:0]     unstable_cnt_q;
  logic [VW-1:0]     vote_cnt_q;
  logic [VW-1:0]     ones_cnt_q;
  logic [SW-1:0]     settle_cnt_q;

  // Vote tallies including the arbiter decision captured on this edge.
  logic [VW-1:0]     ones_d;
  logic [VW-1:0]     vote_d;

  always_comb begin
    ones_d = ones_cnt_q + VW'(arb_bit);
    vote_d = vote_cnt_q + VW'(1);
  end

  // NOTE: every state register, including the response word, is cleared by the
  // asynchronous reset so a partial acquisition never leaks into the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      launch_q       <= 1'b0;
      busy_q         <= 1'b0;
      resp_valid_q   <= 1'b0;
      chal_sel_q     <= '0;
      resp_data_q    <= '0;
      unstable_cnt_q <= '0;
      vote_cnt_q     <= '0;
      ones_cnt_q     <= '0;
      settle_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            resp_data_q    <= '0;
            unstable_cnt_q <= '0;
            chal_sel_q     <= '0;
            vote_cnt_q     <= '0;
            ones_cnt_q     <= '0;
            launch_q       <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= LAUNCH;
          end
        end
        LAUNCH: begin
          launch_q     <= 1'b0;
          settle_cnt_q <= '0;
          state_q      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
          end else begin
            settle_cnt_q <= settle_cnt_q + SW'(1);
          end
        end
        SAMPLE: begin
          if (vote_d == VOTE_ALL) begin
            resp_data_q[chal_sel_q] <= (ones_d > VOTE_MAJ);
            if (ones_d != '0 && ones_d != VOTE_ALL) begin
              unstable_cnt_q <= unstable_cnt_q + UW'(1);
            end
            vote_cnt_q <= '0;
            ones_cnt_q <= '0;
            if (chal_sel_q == CHAL_LAST) begin
              resp_valid_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              chal_sel_q <= chal_sel_q + CW'(1);
              launch_q   <= 1'b1;
              state_q    <= LAUNCH;
            end
          end else begin
            vote_cnt_q <= vote_d;
            ones_cnt_q <= ones_d;
            launch_q   <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          launch_q     <= 1'b0;
          busy_q       <= 1'b0;
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign launch       = launch_q;
  assign busy         = busy_q;
  assign resp_valid   = resp_valid_q;
  assign chal_sel     = chal_sel_q;
  assign resp_data    = resp_data_q;
  assign unstable_cnt = unstable_cnt_q;

endmodule

// File: tb/tb_puf_resp_vote.sv
// Directed bench for puf_resp_vote with RESP_W=4, VOTE_N=3, SETTLE_CYC=2:
// arbiter votes come from a per-launch table, expected words are hand-computed.
module tb_puf_resp_vote;

  localparam int RESP_W     = 4;
  localparam int VOTE_N     = 3;
  localparam int SETTLE_CYC = 2;
  localparam int LATENCY    = RESP_W * VOTE_N * (SETTLE_CYC + 2);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       launch;
  logic [1:0] chal_sel;
  logic       arb_bit;
  logic       busy;
  logic       resp_valid;
  logic       resp_ready;
  logic [3:0] resp_data;
  logic [2:0] unstable_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  int          launch_cnt = 0;
  logic [11:0] pattern = '0;

  puf_resp_vote #(
    .RESP_W    (RESP_W),
    .VOTE_N    (VOTE_N),
    .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .launch      (launch),
    .chal_sel    (chal_sel),
    .arb_bit     (arb_bit),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .unstable_cnt(unstable_cnt)
  );

  always #5 clk = ~clk;

  // Arbiter model: launch number n (bit n/3, vote n%3) answers with pattern[n].
  always @(negedge clk) begin
    if (launch) begin
      launch_cnt = launch_cnt + 1;
      arb_bit    = (launch_cnt <= 12) ? pattern[launch_cnt-1] : 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_acq(input string tag, input logic [11:0] pat, input logic hold_start,
                         input logic stall, input logic [3:0] exp_data, input logic [2:0] exp_unst);
    int lat;
    pattern    = pat;
    launch_cnt = 0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = hold_start;
    check({tag, " first launch"}, 32'(launch), 32'd1);
    check({tag, " first chal_sel"}, 32'(chal_sel), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd1);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(LATENCY));
    check({tag, " launches"}, 32'(launch_cnt), 32'd12);
    check({tag, " resp_data"}, 32'(resp_data), 32'(exp_data));
    check({tag, " unstable_cnt"}, 32'(unstable_cnt), 32'(exp_unst));
    check({tag, " chal_sel done"}, 32'(chal_sel), 32'd3);
    if (stall) begin
      for (int j = 0; j < 10; j++) begin
        start = (j % 2 == 0);
        @(posedge clk); #1;
        check({tag, " stall valid"}, 32'(resp_valid), 32'd1);
        check({tag, " stall data"}, 32'(resp_data), 32'(exp_data));
        check({tag, " stall launch"}, 32'(launch), 32'd0);
      end
      check({tag, " stall launches"}, 32'(launch_cnt), 32'd12);
    end
    resp_ready = 1'b1;
    start      = stall;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    start      = 1'b0;
    check({tag, " valid after ready"}, 32'(resp_valid), 32'd0);
    check({tag, " busy after ready"}, 32'(busy), 32'd0);
    check({tag, " data held"}, 32'(resp_data), 32'(exp_data));
    check({tag, " chal_sel held"}, 32'(chal_sel), 32'd3);
    @(posedge clk); #1;
    check({tag, " stays idle"}, 32'(busy), 32'd0);
    check({tag, " no relaunch"}, 32'(launch), 32'd0);
  endtask

  initial begin
    int guard;
    rst_n      = 1'b0;
    start      = 1'b0;
    resp_ready = 1'b0;
    arb_bit    = 1'b0;
    #1;
    check("reset launch", 32'(launch), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(resp_valid), 32'd0);
    check("reset chal_sel", 32'(chal_sel), 32'd0);
    check("reset data", 32'(resp_data), 32'd0);
    check("reset unstable", 32'(unstable_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All ones, with a stalled consumer and start pulses while DONE.
    run_acq("ones", 12'hFFF, 1'b0, 1'b1, 4'hF, 3'd0);
    // arb_bit = ~chal_sel[0]: bits 0 and 2 vote 1.
    run_acq("alt", 12'h1C7, 1'b0, 1'b0, 4'b0101, 3'd0);
    // Bit 1 votes 1,1,0 and bit 2 votes 0,1,0.
    run_acq("split", 12'h098, 1'b0, 1'b0, 4'b0010, 3'd2);
    // start held high through LAUNCH/SETTLE/SAMPLE must not disturb the run.
    run_acq("start held", 12'h098, 1'b1, 1'b0, 4'b0010, 3'd2);

    // Abort during the SETTLE of challenge 2.
    pattern    = 12'hFFF;
    launch_cnt = 0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (chal_sel == 2'd2 && launch) begin
        guard = 1;
        break;
      end
    end
    check("reach chal 2", 32'(guard), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort launch", 32'(launch), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort valid", 32'(resp_valid), 32'd0);
    check("abort chal_sel", 32'(chal_sel), 32'd0);
    check("abort data", 32'(resp_data), 32'd0);
    check("abort unstable", 32'(unstable_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_acq("after abort", 12'h1C7, 1'b0, 1'b0, 4'b0101, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
